// File: rtl/vram_con_pkg.sv
`default_nettype none
// ============================================================================
// vram_con_pkg : shared constants and FSM encoding for the VRAM write arbiter
// Rev 1.0
// ============================================================================
package vram_con_pkg;

    localparam int COLS_DEFAULT       = 80;
    localparam int ROWS_DEFAULT       = 60;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_PUT    = 3'd2,
        S_BS     = 3'd3,
        S_CLR    = 3'd4
    } con_state_t;

    localparam logic [7:0] c_CR       = 8'h0D;
    localparam logic [7:0] c_LF       = 8'h0A;
    localparam logic [7:0] c_BS       = 8'h08;
    localparam logic [7:0] c_PRINT_LO = 8'h20;
    localparam logic [7:0] c_PRINT_HI = 8'h7E;

    function automatic logic f_printable(input logic [7:0] b);
        return (b >= c_PRINT_LO) && (b <= c_PRINT_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/con_byte_fifo.sv
`default_nettype none
// ============================================================================
// con_byte_fifo : byte FIFO for received console characters (DEPTH >= 2, pow2)
// Rev 1.0
// ============================================================================
module con_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_ovf     = i_push & o_full & ~w_do_pop;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/vram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// vram_wr_arbiter : shares the VRAM write port between CPU and a UART console
// Rev 1.0
// ============================================================================
module vram_wr_arbiter
    import vram_con_pkg::*;
#(
    parameter int          COLS       = COLS_DEFAULT,
    parameter int          ROWS       = ROWS_DEFAULT,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter logic [7:0]  BLANK      = 8'h20
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        cpu_we,
    input  logic [13:0] cpu_x_y,
    input  logic [10:0] cpu_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        con_en,
    input  logic [2:0]  con_attr,
    input  logic        ovf_clr,
    output logic        vram_we,
    output logic [12:0] vram_addr,
    output logic [10:0] vram_data,
    output logic [5:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        con_busy,
    output logic        fifo_overflow,
    output logic        cpu_drop
);

    localparam logic [7:0] c_COLS_8   = 8'(COLS);
    localparam logic [6:0] c_COL_LAST = 7'(COLS - 1);
    localparam logic [5:0] c_ROW_LAST = 6'(ROWS - 1);

    con_state_t  r_state, w_state_nx;
    logic [7:0]  r_byte, w_byte_nx;
    logic [5:0]  r_row, w_row_nx, w_row_inc;
    logic [6:0]  r_col, w_col_nx;
    logic [6:0]  r_clr_k, w_clr_k_nx;
    logic        w_pop, w_con_we, w_grant;
    logic [6:0]  w_con_col;
    logic [7:0]  w_con_char;
    logic [7:0]  w_fifo_dout;
    logic        w_fifo_full, w_fifo_empty, w_fifo_ovf;
    logic [5:0]  w_cpu_row;
    logic [7:0]  w_cpu_col;
    logic        w_cpu_ok;
    logic [5:0]  w_wr_row;
    logic [7:0]  w_wr_col;
    logic [10:0] w_wr_data;
    logic        w_wr_en;
    logic [12:0] w_addr;
    logic        r_vram_we, r_cpu_drop, r_ovf;
    logic [12:0] r_vram_addr;
    logic [10:0] r_vram_data;

    con_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .i_push  (rx_valid & con_en),
        .i_din   (rx_byte),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_ovf   (w_fifo_ovf)
    );

    assign w_cpu_row = cpu_x_y[13:8];
    assign w_cpu_col = cpu_x_y[7:0];
    assign w_cpu_ok  = cpu_we && (w_cpu_row <= c_ROW_LAST) && (w_cpu_col < c_COLS_8);
    // A dropped CPU write leaves the port free for the console.
    assign w_grant   = ~w_cpu_ok;
    assign w_row_inc = (r_row == c_ROW_LAST) ? 6'd0 : r_row + 6'd1;

    always_comb begin
        w_state_nx = r_state;
        w_byte_nx  = r_byte;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_clr_k_nx = r_clr_k;
        w_pop      = 1'b0;
        w_con_we   = 1'b0;
        w_con_col  = r_col;
        w_con_char = r_byte;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    w_byte_nx  = w_fifo_dout;
                    w_state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (f_printable(r_byte)) begin
                    w_state_nx = S_PUT;
                end else if (r_byte == c_CR) begin
                    w_col_nx   = 7'd0;
                    w_state_nx = S_IDLE;
                end else if (r_byte == c_LF) begin
                    w_col_nx   = 7'd0;
                    w_row_nx   = w_row_inc;
                    w_state_nx = S_CLR;
                end else if ((r_byte == c_BS) && (r_col != 7'd0)) begin
                    w_col_nx   = r_col - 7'd1;
                    w_state_nx = S_BS;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_PUT: begin
                if (w_grant) begin
                    w_con_we = 1'b1;
                    if (r_col < c_COL_LAST) begin
                        w_col_nx   = r_col + 7'd1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_col_nx   = 7'd0;
                        w_row_nx   = w_row_inc;
                        w_state_nx = S_CLR;
                    end
                end
            end
            S_BS: begin
                w_con_char = BLANK;
                if (w_grant) begin
                    w_con_we   = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            S_CLR: begin
                w_con_col  = r_clr_k;
                w_con_char = BLANK;
                if (w_grant) begin
                    w_con_we = 1'b1;
                    if (r_clr_k == c_COL_LAST) begin
                        w_clr_k_nx = 7'd0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_clr_k_nx = r_clr_k + 7'd1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= S_IDLE;
            r_byte  <= 8'd0;
            r_row   <= 6'd0;
            r_col   <= 7'd0;
            r_clr_k <= 7'd0;
        end else begin
            r_state <= w_state_nx;
            r_byte  <= w_byte_nx;
            r_row   <= w_row_nx;
            r_col   <= w_col_nx;
            r_clr_k <= w_clr_k_nx;
        end
    end

    assign w_wr_en   = w_cpu_ok | w_con_we;
    assign w_wr_row  = w_cpu_ok ? w_cpu_row : r_row;
    assign w_wr_col  = w_cpu_ok ? w_cpu_col : {1'b0, w_con_col};
    assign w_wr_data = w_cpu_ok ? cpu_data  : {con_attr, w_con_char};

    generate
        if (COLS == 80) begin : g_addr_shift
            assign w_addr = ({7'd0, w_wr_row} << 6) + ({7'd0, w_wr_row} << 4) + {5'd0, w_wr_col};
        end else begin : g_addr_mul
            assign w_addr = 13'((int'(w_wr_row) * COLS) + int'(w_wr_col));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_vram_we   <= 1'b0;
            r_vram_addr <= 13'd0;
            r_vram_data <= 11'd0;
            r_cpu_drop  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_vram_we  <= w_wr_en;
            r_cpu_drop <= cpu_we & ~w_cpu_ok;
            if (w_wr_en) begin
                r_vram_addr <= w_addr;
                r_vram_data <= w_wr_data;
            end
            if (w_fifo_ovf)   r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign vram_we       = r_vram_we;
    assign vram_addr     = r_vram_addr;
    assign vram_data     = r_vram_data;
    assign cursor_row    = r_row;
    assign cursor_col    = r_col;
    assign cpu_drop      = r_cpu_drop;
    assign fifo_overflow = r_ovf;
    assign con_busy      = (r_state != S_IDLE) | ~w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_vram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vram_wr_arbiter : scoreboard bench for the VRAM write arbiter
// Rev 1.0
// ============================================================================
module tb_vram_wr_arbiter;

    typedef struct {
        int          due;
        logic [12:0] addr;
        logic [10:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        clrn, cpu_we, rx_valid, con_en, ovf_clr;
    logic [13:0] cpu_x_y;
    logic [10:0] cpu_data;
    logic [7:0]  rx_byte;
    logic [2:0]  con_attr;
    logic        vram_we, con_busy, fifo_overflow, cpu_drop;
    logic [12:0] vram_addr;
    logic [10:0] vram_data;
    logic [5:0]  cursor_row;
    logic [6:0]  cursor_col;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pos    = 0;
    exp_t cpu_q[$];
    exp_t con_q[$];
    int   drop_q[$];
    int   m_row, m_col;

    always #10 clk = ~clk;
    always @(posedge clk) n_pos <= n_pos + 1;

    vram_wr_arbiter dut (
        .clk           (clk),
        .clrn          (clrn),
        .cpu_we        (cpu_we),
        .cpu_x_y       (cpu_x_y),
        .cpu_data      (cpu_data),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .con_en        (con_en),
        .con_attr      (con_attr),
        .ovf_clr       (ovf_clr),
        .vram_we       (vram_we),
        .vram_addr     (vram_addr),
        .vram_data     (vram_data),
        .cursor_row    (cursor_row),
        .cursor_col    (cursor_col),
        .con_busy      (con_busy),
        .fifo_overflow (fifo_overflow),
        .cpu_drop      (cpu_drop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: CPU writes are due on a fixed cycle, anything else must be the next console write.
    always @(negedge clk) begin : mon
        exp_t e;
        if (cpu_q.size() > 0 && cpu_q[0].due == n_pos) begin
            e = cpu_q.pop_front();
            n_checks++;
            if (!vram_we || vram_addr !== e.addr || vram_data !== e.data) begin
                n_errors++;
                $display("FAIL cpu_write: got we=%0b addr=%0d data=%0h expected addr=%0d data=%0h",
                         vram_we, vram_addr, vram_data, e.addr, e.data);
            end
        end else if (vram_we) begin
            n_checks++;
            if (con_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h expected none", vram_addr, vram_data);
            end else begin
                e = con_q.pop_front();
                if (vram_addr !== e.addr || vram_data !== e.data) begin
                    n_errors++;
                    $display("FAIL con_write: got addr=%0d data=%0h expected addr=%0d data=%0h",
                             vram_addr, vram_data, e.addr, e.data);
                end
            end
        end
        if (drop_q.size() > 0 && drop_q[0] == n_pos) begin
            void'(drop_q.pop_front());
            chk("cpu_drop", {31'd0, cpu_drop}, 32'd1);
        end else if (cpu_drop) begin
            chk("cpu_drop_unexpected", {31'd0, cpu_drop}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic con_push(input int addr, input logic [7:0] ch);
        exp_t e;
        e.due  = 0;
        e.addr = 13'(addr);
        e.data = {3'b010, ch};
        con_q.push_back(e);
    endtask

    task automatic push_clear(input int row);
        for (int k = 0; k < 80; k++) con_push(row * 80 + k, 8'h20);
    endtask

    // Reference cursor model for console bytes (attribute fixed at 3'b010).
    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            con_push(m_row * 80 + m_col, b);
            if (m_col < 79) m_col++;
            else begin
                m_col = 0;
                m_row = (m_row + 1) % 60;
                push_clear(m_row);
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % 60;
            push_clear(m_row);
        end else if (b == 8'h08 && m_col > 0) begin
            m_col--;
            con_push(m_row * 80 + m_col, 8'h20);
        end
    endtask

    task automatic cpu_wr(input logic [13:0] xy, input logic [10:0] d, input bit ok, input int exp_addr);
        exp_t e;
        cpu_we   = 1'b1;
        cpu_x_y  = xy;
        cpu_data = d;
        if (ok) begin
            e.due  = n_pos + 1;
            e.addr = 13'(exp_addr);
            e.data = d;
            cpu_q.push_back(e);
        end else begin
            drop_q.push_back(n_pos + 1);
        end
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        model_byte(b);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!con_busy) break;
        end
        if (i == 400) chk(name, {31'd0, con_busy}, 32'd0);
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        push_rx(b);
        wait_idle("idle_timeout");
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; cpu_we = 1'b0; cpu_x_y = '0; cpu_data = '0;
        rx_valid = 1'b0; rx_byte = '0; con_en = 1'b0; con_attr = 3'b000; ovf_clr = 1'b0;
        m_row = 0; m_col = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_we",   {31'd0, vram_we}, 32'd0);
        chk("rst_addr", {19'd0, vram_addr}, 32'd0);
        chk("rst_data", {21'd0, vram_data}, 32'd0);
        chk("rst_row",  {26'd0, cursor_row}, 32'd0);
        chk("rst_col",  {25'd0, cursor_col}, 32'd0);
        chk("rst_busy", {31'd0, con_busy}, 32'd0);
        chk("rst_ovf",  {31'd0, fifo_overflow}, 32'd0);
        chk("rst_drop", {31'd0, cpu_drop}, 32'd0);
        tick();
        clrn = 1'b1;
        tick();

        // CPU in-range write and two out-of-range drops
        cpu_wr({6'd2, 8'd5}, 11'h241, 1'b1, 165);
        tick();
        cpu_wr({6'd0, 8'd80}, 11'h111, 1'b0, 0);
        tick();
        cpu_wr({6'd60, 8'd0}, 11'h122, 1'b0, 0);
        tick();

        // Console printable and backspace
        con_en   = 1'b1;
        con_attr = 3'b010;
        send(8'h41);
        chk("col_after_A", {25'd0, cursor_col}, 32'd1);
        chk("row_after_A", {26'd0, cursor_row}, 32'd0);
        send(8'h08);
        chk("col_after_bs", {25'd0, cursor_col}, 32'd0);

        // Wrap at end of row 0, then walk down to row 59 and wrap to row 0
        for (int i = 0; i < 79; i++) send(8'h30 + 8'(i % 40));
        send(8'h5A);
        chk("row_after_wrap0", {26'd0, cursor_row}, 32'd1);
        chk("col_after_wrap0", {25'd0, cursor_col}, 32'd0);
        chk("clr_row1_done",   32'(con_q.size()), 32'd0);
        for (int i = 0; i < 58; i++) send(8'h0A);
        chk("row_after_lf", {26'd0, cursor_row}, 32'd59);
        for (int i = 0; i < 79; i++) send(8'h41 + 8'(i % 26));
        send(8'h5A);
        chk("row_after_wrap59", {26'd0, cursor_row}, 32'd0);
        chk("col_after_wrap59", {25'd0, cursor_col}, 32'd0);
        chk("clr_row0_done",    32'(con_q.size()), 32'd0);

        // CPU strobes every other cycle while clearing row 1
        push_rx(8'h0A);
        repeat (3) tick();
        for (int i = 0; i < 20; i++) begin
            cpu_wr({6'd10, 8'(i)}, 11'h500 + 11'(i), 1'b1, 800 + i);
            tick();
        end
        wait_idle("cpu_clr_timeout");
        chk("row_after_cpu_clr", {26'd0, cursor_row}, 32'd1);
        chk("cpu_q_drained",     32'(cpu_q.size()), 32'd0);

        // FIFO overflow during a clear: only the first four bytes survive
        push_rx(8'h0A);
        repeat (4) tick();
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1;
            rx_byte  = 8'h61 + 8'(i);
            if (i < 4) model_byte(8'h61 + 8'(i));
            tick();
        end
        rx_valid = 1'b0;
        chk("ovf_set", {31'd0, fifo_overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, fifo_overflow}, 32'd0);
        wait_idle("ovf_timeout");
        chk("row_after_ovf", {26'd0, cursor_row}, 32'd2);
        chk("col_after_ovf", {25'd0, cursor_col}, 32'd4);

        // Reset in the middle of a clear abandons the remaining writes
        push_rx(8'h0A);
        repeat (10) tick();
        clrn = 1'b0;
        tick();
        con_q.delete();
        @(negedge clk);
        chk("mid_rst_we",   {31'd0, vram_we}, 32'd0);
        chk("mid_rst_addr", {19'd0, vram_addr}, 32'd0);
        chk("mid_rst_data", {21'd0, vram_data}, 32'd0);
        chk("mid_rst_row",  {26'd0, cursor_row}, 32'd0);
        chk("mid_rst_col",  {25'd0, cursor_col}, 32'd0);
        chk("mid_rst_busy", {31'd0, con_busy}, 32'd0);
        tick();
        clrn  = 1'b1;
        m_row = 0;
        m_col = 0;
        repeat (100) tick();
        chk("post_rst_busy", {31'd0, con_busy}, 32'd0);

        chk("con_q_empty",  32'(con_q.size()), 32'd0);
        chk("cpu_q_empty",  32'(cpu_q.size()), 32'd0);
        chk("drop_q_empty", 32'(drop_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
